vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameters H_ACTIVE (default 1440), H_FP (80), H_SYNC (152), H_BP (232), V_ACTIVE (900), V_FP (1), V_SYNC (3), V_BP (28), HSYNC_POL (0: active-low), VSYNC_POL (1: active-high).
REQ-002 Derived totals SHALL be H_TOTAL = sum of the H_* parameters (1904) and V_TOTAL = sum of the V_* parameters (932).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  pixel clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 r_in, g_in, b_in  in  4 each  pixel colour for the current draw_x/draw_y, combinational from the pixel generator.
REQ-007 draw_x  out  11  current horizontal count, 0..H_TOTAL-1.
REQ-008 draw_y  out  11  current vertical count, 0..V_TOTAL-1.
REQ-009 hsync, vsync  out  1 each  sync pulses, driven at the polarity set by HSYNC_POL and VSYNC_POL.
REQ-010 vga_r, vga_g, vga_b  out  4 each  registered colour to the DAC pins.
REQ-011 frame_tick  out  1  one-cycle pulse, once per frame, for game-state update.

Function
REQ-012 hcount SHALL increment by 1 every clk; at H_TOTAL-1 it SHALL wrap to 0.
REQ-013 vcount SHALL increment only when hcount wraps; at V_TOTAL-1 it SHALL wrap to 0 together with hcount.
REQ-014 draw_x and draw_y SHALL be the hcount and vcount registers directly, with zero latency.
REQ-015 active SHALL be asserted when hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-016 hsync SHALL be active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (1520..1671).
REQ-017 vsync SHALL be active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (901..903); vsync is a function of vcount only.
REQ-018 All sync and colour outputs SHALL be registered once, with 1-cycle latency from the draw_x/draw_y they describe. At each edge, sync and colour SHALL reflect the counter value from the cycle before, so they stay aligned with the sampled r_in/g_in/b_in.
REQ-019 vga_r/g/b SHALL equal the previous cycle's r_in/g_in/b_in when the previous cycle was active, and SHALL be 0 otherwise (blanking forced regardless of input).
REQ-020 frame_tick SHALL be registered high for exactly one cycle, in the cycle after hcount=H_TOTAL-1 and vcount=V_TOTAL-1.
REQ-021 The arithmetic SHALL be unsigned 11-bit; parameter sums SHALL NOT exceed 2047.
REQ-022 The counters SHALL never reach H_TOTAL or V_TOTAL; any out-of-range value SHALL wrap to 0 on the next edge.
REQ-023 The block SHALL have no handshake; the downstream pixel generator is combinational and SHALL be sampled every cycle.

Reset
REQ-024 While rst=1 at an edge: hcount=vcount=0; vga_r/g/b=0; frame_tick=0; hsync=~HSYNC_POL; vsync=~VSYNC_POL.
REQ-025 Reset asserted mid-frame SHALL take effect at the next edge with no partial line completed; counting SHALL resume from (0,0) on the first edge after rst deasserts.

Verification
REQ-026 Hold rst for 3 cycles -> draw_x=0, draw_y=0, vga_rgb=0, hsync=1, vsync=0, frame_tick=0.
REQ-027 Release rst and run 1904 cycles -> draw_x steps 0..1903, then 0; draw_y steps 0->1 on the wrap.
REQ-028 Run a full line -> hsync low for exactly 152 consecutive cycles, first low cycle one clk after draw_x=1520; vsync high for exactly 3*1904 cycles per frame.
REQ-029 Hold r_in=0xD, g_in=0x7, b_in=0x8 -> output 0xD/0x7/0x8 one cycle after draw_x=0..1439 with draw_y<900; output 0 one cycle after draw_x=1440, and on all lines 900..931.
REQ-030 Run 2 full frames -> frame_tick pulses exactly twice, 1,774,528 cycles apart, each 1 cycle wide.
REQ-031 Assert rst for 1 cycle at draw_x=700, draw_y=450 -> next edge draw_x=0, draw_y=0, vga_rgb=0; normal counting resumes.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-generator inputs and DAC/sync outputs of the VGA timing generator
interface vga_timing_gen_if;
  logic [3:0]  r_in, g_in, b_in;
  logic [10:0] draw_x, draw_y;
  logic        hsync, vsync, frame_tick;
  logic [3:0]  vga_r, vga_g, vga_b;
  modport master (
    input  r_in, g_in, b_in,
    output draw_x, draw_y, hsync, vsync, vga_r, vga_g, vga_b, frame_tick
  );
  modport slave (
    output r_in, g_in, b_in,
    input  draw_x, draw_y, hsync, vsync, vga_r, vga_g, vga_b, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered sync, blanking and frame tick
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1440,
  parameter int H_FP      = 80,
  parameter int H_SYNC    = 152,
  parameter int H_BP      = 232,
  parameter int V_ACTIVE  = 900,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 28,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b1
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
  logic [10:0] hcount, vcount;
  logic h_end, v_end, v_over, active, hs, vs;
  assign vif.draw_x = hcount;
  assign vif.draw_y = vcount;
  always_comb begin
    h_end  = hcount >= H_LAST;
    v_end  = vcount >= V_LAST;
    v_over = vcount > V_LAST;
    active = (hcount < HA) && (vcount < VA);
    hs     = (hcount >= HS0) && (hcount < HS1);
    vs     = (vcount >= VS0) && (vcount < VS1);
  end
  // outputs describe the pre-edge counter so they align with the sampled colour
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount         <= '0;
      vcount         <= '0;
      vif.hsync      <= ~HSYNC_POL;
      vif.vsync      <= ~VSYNC_POL;
      vif.vga_r      <= '0;
      vif.vga_g      <= '0;
      vif.vga_b      <= '0;
      vif.frame_tick <= 1'b0;
    end else begin
      hcount         <= h_end ? '0 : hcount + 11'd1;
      vcount         <= (v_over || (h_end && v_end)) ? '0 : h_end ? vcount + 11'd1 : vcount;
      vif.hsync      <= hs ? HSYNC_POL : ~HSYNC_POL;
      vif.vsync      <= vs ? VSYNC_POL : ~VSYNC_POL;
      vif.vga_r      <= active ? vif.r_in : '0;
      vif.vga_g      <= active ? vif.g_in : '0;
      vif.vga_b      <= active ? vif.b_in : '0;
      vif.frame_tick <= h_end && v_end;
    end
  end
endmodule
